// File: rtl/ff_chk_pkg.sv
// Shared encodings for the flip-flop checker: FSM states, model modes, JK codes.
package ff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic MODE_D  = 1'b0;
    localparam logic MODE_JK = 1'b1;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/ff_chk_model.sv
// Shadow next-state function of the flop under check (D or JK behaviour).
module ff_chk_model
    import ff_chk_pkg::*;
(
    input  logic mode,
    input  logic dut_rst,
    input  logic d,
    input  logic j,
    input  logic k,
    input  logic dut_q,
    output logic exp_q_next
);

    logic [1:0] w_jk;

    assign w_jk = {j, k};

    // Hold and toggle follow the observed output so the model resyncs after an error.
    always_comb begin
        exp_q_next = 1'b0;
        if (dut_rst) begin
            exp_q_next = 1'b0;
        end else if (mode == MODE_D) begin
            exp_q_next = d;
        end else begin
            case (w_jk)
                JK_HOLD: exp_q_next = dut_q;
                JK_RST:  exp_q_next = 1'b0;
                JK_SET:  exp_q_next = 1'b1;
                JK_TGL:  exp_q_next = ~dut_q;
                default: exp_q_next = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ff_checker.sv
// Runtime checker comparing an observed D/JK flop against a one-cycle shadow model.
module ff_checker
    import ff_chk_pkg::*;
#(
    parameter int unsigned ERR_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             clear,
    input  logic             mode,
    input  logic             stop_on_err,
    input  logic             dut_rst,
    input  logic             d,
    input  logic             j,
    input  logic             k,
    input  logic             dut_q,
    input  logic             dut_q_bar,
    output logic             err_pulse,
    output logic             fail,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       state
);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_exp_q;
    logic               w_exp_q_next;
    logic               w_cmp;
    logic               w_mismatch;
    logic               w_err;
    logic               r_err_pulse;
    logic               r_fail;
    logic [ERR_W-1:0]   r_err_count;
    logic [CNT_W-1:0]   r_check_count;
    logic [CNT_W-1:0]   r_first_err_idx;

    ff_chk_model u_model (
        .mode       (mode),
        .dut_rst    (dut_rst),
        .d          (d),
        .j          (j),
        .k          (k),
        .dut_q      (dut_q),
        .exp_q_next (w_exp_q_next)
    );

    // Shadow expected value, captured every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_q <= 1'b0;
        end else begin
            r_exp_q <= w_exp_q_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and compare qualification; clear overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_cmp        = 1'b0;
        w_mismatch   = (dut_q != r_exp_q) || ((mode == MODE_JK) && (dut_q_bar == dut_q));
        case (r_state)
            ST_IDLE: begin
                if (chk_en) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                w_state_next = chk_en ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                if (!chk_en) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cmp = 1'b1;
                    if (w_mismatch && stop_on_err) w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = ST_IDLE;
            w_cmp        = 1'b0;
        end
    end

    assign w_err = w_cmp && w_mismatch;

    // Counters and error flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_err_pulse     <= 1'b0;
            r_fail          <= 1'b0;
            r_err_count     <= '0;
            r_check_count   <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_cmp) begin
                r_check_count <= r_check_count + CNT_W'(1);
            end
            if (w_err) begin
                r_fail <= 1'b1;
                if (r_err_count != {ERR_W{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
                if (!r_fail) begin
                    r_first_err_idx <= r_check_count;
                end
            end
        end
    end

    assign err_pulse     = r_err_pulse;
    assign fail          = r_fail;
    assign err_count     = r_err_count;
    assign check_count   = r_check_count;
    assign first_err_idx = r_first_err_idx;
    assign state         = r_state;

endmodule

// File: tb/tb_ff_checker.sv
// Directed self-checking bench for ff_checker (default build plus a narrow-counter build).
module tb_ff_checker;

    logic clk = 1'b0;
    logic reset, chk_en, clear, mode, stop_on_err, dut_rst, d, j, k;
    logic dut_q, dut_q_bar;
    logic fq = 1'b0;
    logic inv_q, stuck0, force_qb;

    logic        err_pulse, fail;
    logic [7:0]  err_count;
    logic [15:0] check_count, first_err_idx;
    logic [1:0]  state;

    logic        err_pulse2, fail2;
    logic [1:0]  err_count2;
    logic [2:0]  check_count2, first_err_idx2;
    logic [1:0]  state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural flop under check, with fault injection on its outputs.
    always @(posedge clk) begin
        if (dut_rst)      fq <= 1'b0;
        else if (!mode)   fq <= d;
        else begin
            case ({j, k})
                2'b00:   fq <= fq;
                2'b01:   fq <= 1'b0;
                2'b10:   fq <= 1'b1;
                default: fq <= ~fq;
            endcase
        end
    end

    assign dut_q     = stuck0 ? 1'b0 : (fq ^ inv_q);
    assign dut_q_bar = force_qb ? dut_q : ~dut_q;

    ff_checker u_dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .clear(clear), .mode(mode),
        .stop_on_err(stop_on_err), .dut_rst(dut_rst), .d(d), .j(j), .k(k),
        .dut_q(dut_q), .dut_q_bar(dut_q_bar), .err_pulse(err_pulse), .fail(fail),
        .err_count(err_count), .check_count(check_count),
        .first_err_idx(first_err_idx), .state(state)
    );

    ff_checker #(.ERR_W(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(reset), .chk_en(chk_en), .clear(clear), .mode(mode),
        .stop_on_err(stop_on_err), .dut_rst(dut_rst), .d(d), .j(j), .k(k),
        .dut_q(dut_q), .dut_q_bar(dut_q_bar), .err_pulse(err_pulse2), .fail(fail2),
        .err_count(err_count2), .check_count(check_count2),
        .first_err_idx(first_err_idx2), .state(state2)
    );

    typedef struct {
        logic        en, clr, stop, inv, d;
        logic [1:0]  st;
        logic        pulse, fail;
        logic [7:0]  errc;
        logic [15:0] chkc, fidx;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input int en, input int clr, input int stop, input int inv,
                                input int dd, input int st, input int pulse, input int fl,
                                input int errc, input int chkc, input int fidx);
        vec_t v;
        v.en = 1'(en); v.clr = 1'(clr); v.stop = 1'(stop); v.inv = 1'(inv); v.d = 1'(dd);
        v.st = 2'(st); v.pulse = 1'(pulse); v.fail = 1'(fl);
        v.errc = 8'(errc); v.chkc = 16'(chkc); v.fidx = 16'(fidx);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        chk_en = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           en clr stp inv d  st pl fl err cnt fidx
        tbl[0]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 2, 0);
        tbl[4]  = mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 3, 0);
        tbl[5]  = mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 4, 0);
        tbl[6]  = mk(1, 0, 1, 1, 1, 3, 1, 1, 1, 5, 4);
        tbl[7]  = mk(1, 0, 1, 0, 0, 3, 0, 1, 1, 5, 4);
        tbl[8]  = mk(0, 0, 1, 0, 1, 3, 0, 1, 1, 5, 4);
        tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        tbl[13] = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; chk_en = 1'b0; clear = 1'b0; mode = 1'b0; stop_on_err = 1'b0;
        dut_rst = 1'b0; d = 1'b0; j = 1'b0; k = 1'b0;
        inv_q = 1'b0; stuck0 = 1'b0; force_qb = 1'b0;
        tick(); tick();
        reset = 1'b0;

        chk("rst state", int'(state), 0);
        chk("rst err_pulse", int'(err_pulse), 0);
        chk("rst fail", int'(fail), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst check_count", int'(check_count), 0);
        chk("rst first_err_idx", int'(first_err_idx), 0);

        // Stop-on-error halt, frozen counters, clear from HALT, clear beating a mismatch.
        for (int i = 0; i < 15; i++) begin
            chk_en = tbl[i].en; clear = tbl[i].clr; stop_on_err = tbl[i].stop;
            inv_q = tbl[i].inv; d = tbl[i].d;
            tick();
            chk($sformatf("row%0d state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("row%0d err_pulse", i), int'(err_pulse), int'(tbl[i].pulse));
            chk($sformatf("row%0d fail", i), int'(fail), int'(tbl[i].fail));
            chk($sformatf("row%0d err_count", i), int'(err_count), int'(tbl[i].errc));
            chk($sformatf("row%0d check_count", i), int'(check_count), int'(tbl[i].chkc));
            chk($sformatf("row%0d first_err_idx", i), int'(first_err_idx), int'(tbl[i].fidx));
        end
        clear = 1'b0; inv_q = 1'b0; stop_on_err = 1'b0;

        // D mode, correct flop, 20 enabled edges.
        do_clear();
        mode = 1'b0; chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = 1'((i / 4) % 2);
            tick();
        end
        chk("d20 check_count", int'(check_count), 18);
        chk("d20 err_count", int'(err_count), 0);
        chk("d20 fail", int'(fail), 0);
        chk("d20 state", int'(state), 2);
        chk("d20 narrow check_count wrap", int'(check_count2), 2);
        chk_en = 1'b0;
        tick();
        chk("d20 idle state", int'(state), 0);
        chk("d20 idle check_count", int'(check_count), 18);

        // JK mode, correct flop stepping all codes, then a q_bar fault.
        do_clear();
        mode = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 34; i++) begin
            {j, k} = 2'(i % 4);
            tick();
        end
        chk("jk check_count", int'(check_count), 32);
        chk("jk err_count", int'(err_count), 0);
        {j, k} = 2'b10; force_qb = 1'b1;
        tick();
        force_qb = 1'b0;
        chk("jk qbar err_count", int'(err_count), 1);
        chk("jk qbar err_pulse", int'(err_pulse), 1);
        chk("jk qbar first_err_idx", int'(first_err_idx), 32);
        chk("jk qbar check_count", int'(check_count), 33);
        {j, k} = 2'b11;
        tick();
        chk("jk qbar pulse drop", int'(err_pulse), 0);
        chk("jk qbar err_count hold", int'(err_count), 1);
        chk("jk qbar state", int'(state), 2);

        // Stuck-at-0 output with d=1: saturation in the narrow build.
        do_clear();
        mode = 1'b0; j = 1'b0; k = 1'b0; d = 1'b1; stuck0 = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("stuck err_count", int'(err_count), 6);
        chk("stuck fail", int'(fail), 1);
        chk("stuck first_err_idx", int'(first_err_idx), 0);
        chk("stuck narrow err_count sat", int'(err_count2), 3);
        chk("stuck narrow fail", int'(fail2), 1);
        chk("stuck narrow check_count", int'(check_count2), 6);
        stuck0 = 1'b0; chk_en = 1'b0;
        tick();

        // dut_rst in CHECK, mode change mid-CHECK, then checker reset mid-CHECK.
        do_clear();
        mode = 1'b0; d = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        dut_rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dut_rst = 1'b0; d = 1'b0;
        tick(); tick();
        mode = 1'b1; j = 1'b1; k = 1'b0;
        tick(); tick();
        j = 1'b1; k = 1'b1;
        tick(); tick();
        chk("dutrst err_count", int'(err_count), 0);
        chk("dutrst fail", int'(fail), 0);
        chk("dutrst check_count", int'(check_count), 12);
        chk("dutrst state", int'(state), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0; chk_en = 1'b0;
        chk("midrst state", int'(state), 0);
        chk("midrst check_count", int'(check_count), 0);
        chk("midrst err_count", int'(err_count), 0);
        chk("midrst fail", int'(fail), 0);
        chk("midrst err_pulse", int'(err_pulse), 0);
        chk("midrst first_err_idx", int'(first_err_idx), 0);
        chk("midrst narrow state", int'(state2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
